// File: rtl/psum_requant_relu.sv
// psum_requant_relu
//   Post-processing stage for the weight-stationary conv array. Accepts one
//   SA_COL-wide psum vector per handshake. Each channel gets a programmable
//   bias added, a rounding arithmetic right shift, saturation to signed
//   DATA_WIDTH and an optional ReLU. Channels are emitted serially, ch 0 first.
// Ports
//   clk, nrst                       clock, asynchronous active-low reset
//   cfg_we/cfg_ch/cfg_bias          per-channel bias write (only applied in IDLE)
//   cfg_shift/cfg_relu_en           global shift / ReLU, written with every cfg_we
//   psum_iv/psum_ir/psum_i          input vector stream
//   out_ov/out_ir/out_od            output activation stream
//   out_ch/out_last                 channel index of out_od, last-channel flag
//   busy                            high while a vector is being emitted
//   sat_cnt                         saturated beats delivered, sticks at all-ones
module psum_requant_relu #(
  parameter int SA_COL      = 3,
  parameter int PSUM_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int BIAS_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  localparam int CH_W       = (SA_COL > 1) ? $clog2(SA_COL) : 1
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         cfg_we,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [BIAS_WIDTH-1:0]        cfg_bias,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
  input  logic                         cfg_relu_en,
  input  logic                         psum_iv,
  output logic                         psum_ir,
  input  logic [SA_COL*PSUM_WIDTH-1:0] psum_i,
  output logic                         out_ov,
  input  logic                         out_ir,
  output logic [DATA_WIDTH-1:0]        out_od,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_last,
  output logic                         busy,
  output logic [15:0]                  sat_cnt
);

  localparam int RW = PSUM_WIDTH + 2;
  localparam logic signed [RW-1:0] SAT_MAX = RW'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic                         accept;
  logic                         handshake;
  logic                         cfg_apply;
  logic [SA_COL*PSUM_WIDTH-1:0] vec_q;
  logic signed [BIAS_WIDTH-1:0] bias_q [SA_COL];
  logic [SHIFT_WIDTH-1:0]       shift_q;
  logic                         relu_q;
  logic                         out_sat_q;

  logic [SA_COL*PSUM_WIDTH-1:0] sel_vec;
  logic [CH_W-1:0]              sel_idx;
  logic signed [PSUM_WIDTH-1:0] sel_psum;
  logic signed [BIAS_WIDTH-1:0] sel_bias;
  logic signed [PSUM_WIDTH:0]   sum;
  logic signed [RW-1:0]         sum_x;
  logic signed [RW-1:0]         rnd;
  logic signed [RW-1:0]         shr;
  logic [DATA_WIDTH-1:0]        res_od;
  logic                         res_sat;

  assign busy      = (state_q == EMIT);
  assign handshake = out_ov & out_ir;
  assign psum_ir   = (state_q == IDLE) | (handshake & out_last);
  assign accept    = psum_iv & psum_ir;
  assign cfg_apply = cfg_we & (state_q == IDLE) & ~accept;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EMIT;
      EMIT:    if (handshake & out_last & ~accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result for the next registered beat: ch 0 straight from the input on
  // accept (so it is valid one cycle later), otherwise the following channel
  // from the latched vector.
  always_comb begin
    sel_vec  = accept ? psum_i : vec_q;
    sel_idx  = accept ? '0 : out_ch + CH_W'(1);
    sel_psum = sel_vec[PSUM_WIDTH-1:0];
    sel_bias = bias_q[0];
    for (int unsigned k = 0; k < SA_COL; k++) begin
      if (32'(sel_idx) == k) begin
        sel_psum = sel_vec[k*PSUM_WIDTH +: PSUM_WIDTH];
        sel_bias = bias_q[k];
      end
    end
  end

  always_comb begin
    sum   = {sel_psum[PSUM_WIDTH-1], sel_psum}
          + {{(PSUM_WIDTH + 1 - BIAS_WIDTH){sel_bias[BIAS_WIDTH-1]}}, sel_bias};
    sum_x = {sum[PSUM_WIDTH], sum};
    rnd   = '0;
    shr   = sum_x;
    if (shift_q != '0) begin
      // Shifts past the sum width collapse to the sign instead of letting the
      // rounding constant overflow the working width.
      if (32'(shift_q) > PSUM_WIDTH) begin
        shr = sum[PSUM_WIDTH] ? '1 : '0;
      end else begin
        rnd = RW'(1) << (shift_q - SHIFT_WIDTH'(1));
        shr = (sum_x + rnd) >>> shift_q;
      end
    end
    res_sat = 1'b0;
    res_od  = shr[DATA_WIDTH-1:0];
    if (shr > SAT_MAX) begin
      res_sat = 1'b1;
      res_od  = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shr < SAT_MIN) begin
      res_sat = 1'b1;
      res_od  = SAT_MIN[DATA_WIDTH-1:0];
    end
    // ReLU after saturation: a clamp-to-min still reports as saturated.
    if (relu_q & res_od[DATA_WIDTH-1]) res_od = '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vec_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b1;
      out_ov    <= 1'b0;
      out_od    <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      out_sat_q <= 1'b0;
      sat_cnt   <= '0;
      for (int unsigned k = 0; k < SA_COL; k++) bias_q[k] <= '0;
    end else begin
      if (handshake & out_sat_q & (sat_cnt != '1)) sat_cnt <= sat_cnt + 16'd1;
      if (cfg_apply) begin
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu_en;
        for (int unsigned k = 0; k < SA_COL; k++) begin
          if (32'(cfg_ch) == k) bias_q[k] <= cfg_bias;
        end
      end
      if (accept) begin
        vec_q     <= psum_i;
        out_ov    <= 1'b1;
        out_ch    <= '0;
        out_last  <= (SA_COL == 1);
        out_od    <= res_od;
        out_sat_q <= res_sat;
      end else if (handshake) begin
        if (out_last) begin
          out_ov    <= 1'b0;
          out_last  <= 1'b0;
          out_sat_q <= 1'b0;
        end else begin
          out_ch    <= sel_idx;
          out_last  <= (32'(sel_idx) == SA_COL - 1);
          out_od    <= res_od;
          out_sat_q <= res_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_requant_relu.sv
// Testbench for psum_requant_relu: table-driven vectors, hand-written
// backpressure / back-to-back / config-while-busy / reset sequences, and a
// randomized phase, all cross-checked by a cycle-level scoreboard.
module tb_psum_requant_relu;

  localparam int SA_COL = 3;
  localparam int PW     = 19;
  localparam int DW     = 8;
  localparam int BW     = 16;
  localparam int SW     = 5;
  localparam int CW     = 2;

  logic                   clk;
  logic                   nrst;
  logic                   cfg_we;
  logic [CW-1:0]          cfg_ch;
  logic [BW-1:0]          cfg_bias;
  logic [SW-1:0]          cfg_shift;
  logic                   cfg_relu_en;
  logic                   psum_iv;
  logic                   psum_ir;
  logic [SA_COL*PW-1:0]   psum_i;
  logic                   out_ov;
  logic                   out_ir;
  logic [DW-1:0]          out_od;
  logic [CW-1:0]          out_ch;
  logic                   out_last;
  logic                   busy;
  logic [15:0]            sat_cnt;

  psum_requant_relu #(
    .SA_COL(SA_COL), .PSUM_WIDTH(PW), .DATA_WIDTH(DW),
    .BIAS_WIDTH(BW), .SHIFT_WIDTH(SW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_bias(cfg_bias),
    .cfg_shift(cfg_shift), .cfg_relu_en(cfg_relu_en),
    .psum_iv(psum_iv), .psum_ir(psum_ir), .psum_i(psum_i),
    .out_ov(out_ov), .out_ir(out_ir), .out_od(out_od),
    .out_ch(out_ch), .out_last(out_last), .busy(busy), .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int od;
    int ch;
    bit last;
    bit sat;
    int cyc;
  } beat_t;

  typedef struct {
    int p0, p1, p2;
    int b0, b1, b2;
    int sh;
    bit relu;
    int e0, e1, e2;
    int esat;
  } vec_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    m_bias [SA_COL];
  int    m_shift;
  bit    m_relu;
  int    m_sat;
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  function automatic void check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  // Reference: plain integer arithmetic with floor division for the shift.
  function automatic void ref_beat(input longint p, input longint b, input int sh,
                                   input bit relu, output int od, output bit sat);
    longint s, v, d, r, mx, mn;
    s = p + b;
    if (sh == 0) r = s;
    else if (sh >= PW + 1) r = (s < 0) ? -1 : 0;
    else begin
      d = longint'(1) << sh;
      v = s + d / 2;
      r = v / d;
      if ((v % d != 0) && (v < 0)) r = r - 1;
    end
    mx = (longint'(1) << (DW - 1)) - 1;
    mn = -(longint'(1) << (DW - 1));
    sat = 1'b0;
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
    if (relu && r < 0) r = 0;
    od = int'(r);
  endfunction

  // Scoreboard: sampled mid-cycle, after outputs settle and before the edge.
  always @(negedge clk) begin
    bit    idle, exp_ready, acc, hs;
    beat_t b;
    beat_t nb;
    cyc++;
    if (!nrst) begin
      exp_q.delete();
      for (int k = 0; k < SA_COL; k++) m_bias[k] = 0;
      m_shift = 0;
      m_relu  = 1'b1;
      m_sat   = 0;
    end else begin
      idle      = (exp_q.size() == 0);
      exp_ready = idle || (exp_q.size() == 1 && out_ir);
      check("out_ov", out_ov, !idle);
      check("busy", busy, !idle);
      check("psum_ir", psum_ir, exp_ready);
      check("sat_cnt", sat_cnt, m_sat);
      if (!idle) begin
        check("out_od", $signed(out_od), exp_q[0].od);
        check("out_ch", out_ch, exp_q[0].ch);
        check("out_last", out_last, exp_q[0].last);
      end
      acc = psum_iv && exp_ready;
      hs  = !idle && out_ir;
      if (hs) begin
        b = exp_q.pop_front();
        if (b.sat && m_sat != 65535) m_sat++;
        b.od   = $signed(out_od);
        b.ch   = out_ch;
        b.last = out_last;
        b.cyc  = cyc;
        obs_q.push_back(b);
      end
      if (cfg_we && idle && !acc) begin
        m_shift = cfg_shift;
        m_relu  = cfg_relu_en;
        if (cfg_ch < SA_COL) m_bias[cfg_ch] = $signed(cfg_bias);
      end
      if (acc) begin
        for (int k = 0; k < SA_COL; k++) begin
          ref_beat(longint'($signed(psum_i[k*PW +: PW])), m_bias[k], m_shift, m_relu,
                   nb.od, nb.sat);
          nb.ch   = k;
          nb.last = (k == SA_COL - 1);
          nb.cyc  = 0;
          exp_q.push_back(nb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int bias, input int sh, input bit relu);
    cfg_we      = 1'b1;
    cfg_ch      = CW'(ch);
    cfg_bias    = BW'(bias);
    cfg_shift   = SW'(sh);
    cfg_relu_en = relu;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_vec(input int p0, input int p1, input int p2);
    psum_i = {PW'(p2), PW'(p1), PW'(p0)};
  endtask

  // Holds psum_iv until accepted; leaves psum_iv asserted.
  task automatic offer(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    psum_iv = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = psum_ir;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_vec(input int p0, input int p1, input int p2);
    bit ok;
    int n;
    set_vec(p0, p1, p2);
    offer(ok, n);
    psum_iv = 1'b0;
    check("accept_done", ok, 1);
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 100 && obs_q.size() < n; i++) tick();
    check("beats_arrived", obs_q.size() >= n, 1);
  endtask

  function automatic int rand_psum();
    int v;
    case ($urandom % 3)
      0:       v = int'($urandom_range(0, 511)) - 256;
      1:       v = int'($urandom_range(0, 80000)) - 40000;
      default: v = int'($urandom_range(0, 524287)) - 262144;
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  vec_t  vt [8];
  int    base, sat0, n_after, nacc;
  int    e [3];
  bit    ok;

  initial begin
    vt[0] = '{5, -20, 100, 10, 10, 10, 0, 1, 15, 0, 110, 0};
    vt[1] = '{200, -300, 127, 0, 0, 0, 0, 0, 127, -128, 127, 2};
    vt[2] = '{6, -6, 5, 0, 0, 0, 2, 0, 2, -1, 1, 0};
    vt[3] = '{-1000, 1000, 0, 0, 0, 0, 31, 0, -1, 0, 0, 0};
    vt[4] = '{-5, 5, -262144, 0, 0, 0, 20, 0, -1, 0, -1, 0};
    vt[5] = '{-300, 300, -1, 0, 0, 0, 0, 1, 0, 127, 0, 2};
    vt[6] = '{-262144, 262143, 130, -32768, 32767, -3, 0, 0, -128, 127, 127, 2};
    vt[7] = '{3, -3, 1, 0, 0, 0, 1, 0, 2, -1, 1, 0};

    nrst = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_bias = '0; cfg_shift = '0;
    cfg_relu_en = 1'b0; psum_iv = 1'b0; psum_i = '0; out_ir = 1'b1;
    repeat (3) tick();
    check("rst_out_ov", out_ov, 0);
    check("rst_out_od", out_od, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    check("rst_psum_ir", psum_ir, 1);
    nrst = 1'b1;
    tick();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      cfg_write(0, vt[i].b0, vt[i].sh, vt[i].relu);
      cfg_write(1, vt[i].b1, vt[i].sh, vt[i].relu);
      cfg_write(2, vt[i].b2, vt[i].sh, vt[i].relu);
      base = obs_q.size();
      sat0 = int'(sat_cnt);
      send_vec(vt[i].p0, vt[i].p1, vt[i].p2);
      wait_obs(base + 3);
      e[0] = vt[i].e0; e[1] = vt[i].e1; e[2] = vt[i].e2;
      for (int k = 0; k < 3; k++) begin
        if (obs_q.size() > base + k) begin
          check("vec_od", obs_q[base+k].od, e[k]);
          check("vec_ch", obs_q[base+k].ch, k);
          check("vec_last", obs_q[base+k].last, (k == 2));
        end
      end
      check("vec_sat_delta", int'(sat_cnt) - sat0, vt[i].esat);
    end

    // Backpressure on ch1 for three cycles
    cfg_write(0, 0, 0, 0); cfg_write(1, 0, 0, 0); cfg_write(2, 0, 0, 0);
    base = obs_q.size();
    send_vec(11, 22, 33);
    tick();
    out_ir = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_ch", out_ch, 1);
      check("bp_od", $signed(out_od), 22);
      check("bp_psum_ir", psum_ir, 0);
      @(posedge clk);
      #1;
    end
    out_ir = 1'b1;
    wait_obs(base + 3);
    repeat (3) tick();
    check("bp_beat_count", obs_q.size(), base + 3);

    // Back-to-back vectors with continuous valid
    base = obs_q.size();
    set_vec(1, 2, 3);
    offer(ok, nacc);
    check("b2b_first_accept", ok, 1);
    set_vec(-4, -5, -6);
    offer(ok, nacc);
    psum_iv = 1'b0;
    check("b2b_second_accept", ok, 1);
    check("b2b_accept_on_last", nacc, 3);
    wait_obs(base + 6);
    if (obs_q.size() >= base + 6)
      check("b2b_gap_free", obs_q[base+5].cyc - obs_q[base].cyc, 5);

    // Config write while busy is dropped
    cfg_write(0, 0, 0, 1); cfg_write(1, 0, 0, 1); cfg_write(2, 0, 0, 1);
    base = obs_q.size();
    out_ir = 1'b0;
    send_vec(1, 2, 3);
    cfg_write(0, 50, 0, 1);
    tick();
    out_ir = 1'b1;
    wait_obs(base + 3);
    send_vec(4, 4, 4);
    wait_obs(base + 6);
    if (obs_q.size() >= base + 6) begin
      check("busy_cfg_same_vec", obs_q[base].od, 1);
      check("busy_cfg_next_vec", obs_q[base+3].od, 4);
    end

    // Asynchronous reset during beat ch1
    base = obs_q.size();
    send_vec(7, 8, 9);
    tick();
    #2;
    nrst = 1'b0;
    #1;
    check("arst_out_ov", out_ov, 0);
    check("arst_out_od", out_od, 0);
    check("arst_out_ch", out_ch, 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_sat_cnt", sat_cnt, 0);
    check("arst_psum_ir", psum_ir, 1);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    n_after = obs_q.size();
    repeat (5) tick();
    check("arst_no_stale", obs_q.size(), n_after);
    check("arst_ch0_only", n_after, base + 1);

    // Randomized traffic
    repeat (800) begin
      cfg_we      = ($urandom % 5 == 0);
      cfg_ch      = CW'($urandom % 4);
      cfg_bias    = BW'($urandom);
      cfg_shift   = ($urandom % 2 == 0) ? SW'($urandom % 6) : SW'($urandom);
      cfg_relu_en = 1'($urandom % 2);
      psum_iv     = ($urandom % 3 != 0);
      for (int k = 0; k < SA_COL; k++) psum_i[k*PW +: PW] = PW'(rand_psum());
      out_ir      = ($urandom % 4 != 0);
      tick();
    end
    cfg_we = 1'b0; psum_iv = 1'b0; out_ir = 1'b1;
    repeat (10) tick();
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
